// File: rtl/neuron_output_stage.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_output_stage
//  Purpose  : Final stage of a neuron datapath. Accumulates unsigned 4-lane
//             dot-product partial sums on top of a signed bias, then applies
//             optional ReLU, an arithmetic right shift and an 8-bit clamp.
//             Results are queued in a small output FIFO.
//  Ports    :
//    clk        - clock; all state updates on its rising edge
//    rst        - synchronous reset, active-high
//    in_valid   - in_data / in_last qualify a beat
//    in_data    - unsigned 16-bit partial sum from the MAC stage
//    in_last    - beat closes the current neuron group
//    in_ready   - stage can accept a beat
//    cfg_bias   - signed bias, loaded at group start only
//    cfg_shift  - requantize right-shift amount
//    cfg_relu   - 1: ReLU + unsigned 0..255 output, 0: signed -128..127
//    out_valid  - FIFO non-empty, out_data valid
//    out_data   - result at FIFO head
//    out_ready  - downstream consumes the head entry
//    sat_flag   - sticky accumulator/output saturation indicator
//    fifo_count - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_output_stage #(
    parameter int ACC_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [15:0]                     in_data,
    input  logic                            in_last,
    output logic                            in_ready,
    input  logic [15:0]                     cfg_bias,
    input  logic [3:0]                      cfg_shift,
    input  logic                            cfg_relu,
    output logic                            out_valid,
    output logic [7:0]                      out_data,
    input  logic                            out_ready,
    output logic                            sat_flag,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_u8_max  = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] c_s8_max  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_s8_min  = ACC_W'(-128);

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_first;

    logic                    w_accept;
    logic signed [ACC_W-1:0] w_base;
    logic        [ACC_W:0]   w_sum_wide;
    logic                    w_acc_ovf;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_accept = in_valid && in_ready;

    // A group start replaces the running sum with the sign-extended bias,
    // so a mid-group bias change never reaches the accumulator.
    assign w_base = r_first ? {{(ACC_W-16){cfg_bias[15]}}, cfg_bias} : r_acc;

    // One guard bit is enough: the addend is non-negative, so only the
    // positive limit can be crossed.
    assign w_sum_wide = {w_base[ACC_W-1], w_base} + {{(ACC_W-15){1'b0}}, in_data};
    assign w_acc_ovf  = (w_sum_wide[ACC_W:ACC_W-1] == 2'b01);
    assign w_acc_next = w_acc_ovf ? c_acc_max : $signed(w_sum_wide[ACC_W-1:0]);

    // ------------------------------------------------------------------
    // Stage s1: registered final sum plus the config sampled with in_last
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_s1_sum;
    logic        [3:0]       r_s1_shift;
    logic                    r_s1_relu;
    logic                    r_s1_valid;

    logic signed [ACC_W-1:0] w_relu_val;
    logic signed [ACC_W-1:0] w_shifted;
    logic        [7:0]       w_result;
    logic                    w_clamped;

    assign w_relu_val = (r_s1_relu && r_s1_sum[ACC_W-1]) ? '0 : r_s1_sum;
    assign w_shifted  = w_relu_val >>> r_s1_shift;

    always_comb begin
        w_result  = w_shifted[7:0];
        w_clamped = 1'b0;
        if (r_s1_relu) begin
            // ReLU already removed negatives; only the upper bound applies.
            if (w_shifted > c_u8_max) begin
                w_result  = 8'hFF;
                w_clamped = 1'b1;
            end
        end else begin
            if (w_shifted > c_s8_max) begin
                w_result  = 8'h7F;
                w_clamped = 1'b1;
            end else if (w_shifted < c_s8_min) begin
                w_result  = 8'h80;
                w_clamped = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w:0]   w_occupancy;

    assign w_push = r_s1_valid;
    assign w_pop  = (r_count != '0) && out_ready;

    // Reserving a slot for the entry in s1 guarantees s1 never has to stall.
    assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_s1_valid};
    assign in_ready    = (w_occupancy < (c_cnt_w+1)'(FIFO_DEPTH));

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : 8'd0;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic r_sat;
    assign sat_flag = r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_first    <= 1'b1;
            r_s1_sum   <= '0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sat      <= 1'b0;
        end else begin
            // Accumulator and group tracking
            if (w_accept) begin
                r_acc   <= w_acc_next;
                r_first <= in_last;
            end

            // s1 holds a result for exactly one cycle
            r_s1_valid <= w_accept && in_last;
            if (w_accept && in_last) begin
                r_s1_sum   <= w_acc_next;
                r_s1_shift <= cfg_shift;
                r_s1_relu  <= cfg_relu;
            end

            // Sticky saturation
            if ((w_accept && w_acc_ovf) || (r_s1_valid && w_clamped)) begin
                r_sat <= 1'b1;
            end

            // FIFO pointers and occupancy
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage needs no reset: every read is gated by a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

endmodule
`default_nettype wire
